// File: rtl/ahb_fabric_pkg.sv
// Shared AHB-Lite types and constants for the bus fabric and its default slave.
package ahb_fabric_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped active transfers, plus a
// saturating decode-error counter.
module ahb_default_slave
  import ahb_fabric_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hready,
  input  logic                     trans_active,
  input  logic                     unmapped,
  input  logic                     err_clr,
  output logic                     ds_hready,
  output logic                     ds_hresp,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  ds_state_t                state_reg, state_next;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_reg, err_cnt_next;
  logic                     accept;
  logic                     inc;

  // Outputs depend on state only, so the HREADY feedback through accept is not a loop.
  assign ds_hready = (state_reg != DS_ERR1);
  assign ds_hresp  = (state_reg == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
  assign accept    = hready & trans_active & unmapped;
  assign inc       = accept && (state_reg != DS_ERR1);
  assign err_cnt   = err_cnt_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      DS_IDLE: if (accept) state_next = DS_ERR1;
      DS_ERR1: state_next = DS_ERR2;
      DS_ERR2: state_next = accept ? DS_ERR1 : DS_IDLE;
      default: state_next = DS_IDLE;
    endcase
  end

  always_comb begin
    err_cnt_next = err_cnt_reg;
    if (err_clr)
      err_cnt_next = inc ? ERR_CNT_WIDTH'(1) : '0;
    else if (inc && !(&err_cnt_reg))
      err_cnt_next = err_cnt_reg + ERR_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= DS_IDLE;
      err_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      err_cnt_reg <= err_cnt_next;
    end
  end

endmodule

// File: rtl/ahb_bus_fabric.sv
// Single-master AHB-Lite interconnect: address decoder, registered data-phase
// select, response mux and built-in default slave.
module ahb_bus_fabric
  import ahb_fabric_pkg::*;
#(
  parameter int NUM_SLAVES    = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                             HCLK,
  input  logic                             HRESETn,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [NUM_SLAVES-1:0]            HSEL,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_HRDATA,
  input  logic [NUM_SLAVES-1:0]            s_HREADYOUT,
  input  logic [NUM_SLAVES-1:0]            s_HRESP,
  output logic                             HREADY,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HRESP,
  input  logic                             err_clr,
  output logic [ERR_CNT_WIDTH-1:0]         err_cnt
);

  logic [NUM_SLAVES-1:0] hit;
  logic [NUM_SLAVES-1:0] hsel_c;
  logic                  unmapped;
  logic                  trans_active;
  logic [NUM_SLAVES:0]   sel_reg;
  logic                  active_reg;
  logic                  ds_hready;
  logic                  ds_hresp;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_decode
      assign hit[gi] = (HADDR & SLAVE_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                       == SLAVE_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // Walk from the top down so the lowest-index hit is the one left standing.
  always_comb begin
    hsel_c = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hsel_c    = '0;
        hsel_c[i] = 1'b1;
      end
    end
  end

  assign HSEL         = hsel_c;
  assign unmapped     = ~(|hit);
  assign trans_active = (HTRANS == NONSEQ) || (HTRANS == SEQ);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_reg    <= '0;
      active_reg <= 1'b0;
    end else if (HREADY) begin
      sel_reg    <= {unmapped, hsel_c};
      active_reg <= trans_active;
    end
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    HRDATA = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg[i]) begin
        HREADY = s_HREADYOUT[i];
        HRESP  = s_HRESP[i];
        HRDATA = s_HRDATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    // An inactive default-slave data phase is a plain zero-wait OKAY.
    if (sel_reg[NUM_SLAVES] && active_reg) begin
      HREADY = ds_hready;
      HRESP  = ds_hresp;
    end
  end

  ahb_default_slave #(
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_default_slave (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .hready       (HREADY),
    .trans_active (trans_active),
    .unmapped     (unmapped),
    .err_clr      (err_clr),
    .ds_hready    (ds_hready),
    .ds_hresp     (ds_hresp),
    .err_cnt      (err_cnt)
  );

endmodule

// File: tb/tb_ahb_bus_fabric.sv
// Directed scoreboard bench for ahb_bus_fabric with four slaves on 0x0..0x3000_0000.
module tb_ahb_bus_fabric;
  import ahb_fabric_pkg::*;

  logic         HCLK;
  logic         HRESETn;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [3:0]   HSEL;
  logic [127:0] s_HRDATA;
  logic [3:0]   s_HREADYOUT;
  logic [3:0]   s_HRESP;
  logic         HREADY;
  logic [31:0]  HRDATA;
  logic         HRESP;
  logic         err_clr;
  logic [7:0]   err_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic        rdy;
    logic        resp;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  localparam logic [31:0] D0 = 32'h0000_AAAA;
  localparam logic [31:0] D1 = 32'h1111_1111;
  localparam logic [31:0] D2 = 32'hDEAD_BEEF;
  localparam logic [31:0] D3 = 32'h3333_3333;

  ahb_bus_fabric dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .s_HRDATA    (s_HRDATA),
    .s_HREADYOUT (s_HREADYOUT),
    .s_HRESP     (s_HRESP),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .err_clr     (err_clr),
    .err_cnt     (err_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic expect_dp(input string tag, input logic rdy, input logic resp,
                           input logic [31:0] data);
    exp_t e;
    e.tag  = tag;
    e.rdy  = rdy;
    e.resp = resp;
    e.data = data;
    sb.push_back(e);
  endtask

  // One bus cycle: drive after the edge, then retire one queued data-phase expectation.
  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [3:0] r,
                      input logic clr);
    exp_t e;
    @(posedge HCLK);
    #1;
    HADDR       = a;
    HTRANS      = t;
    s_HREADYOUT = r;
    err_clr     = clr;
    @(negedge HCLK);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_hready"}, 32'(HREADY), 32'(e.rdy));
      chk({e.tag, "_hresp"},  32'(HRESP),  32'(e.resp));
      chk({e.tag, "_hrdata"}, HRDATA,      e.data);
      $display("[TB] %s: hready=%0b hresp=%0b hrdata=%h", e.tag, HREADY, HRESP, HRDATA);
    end
  endtask

  initial begin
    HRESETn     = 1'b0;
    HADDR       = 32'h0;
    HTRANS      = IDLE;
    s_HRDATA    = {D3, D2, D1, D0};
    s_HREADYOUT = 4'hF;
    s_HRESP     = 4'h0;
    err_clr     = 1'b0;
    #2;
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp",  32'(HRESP),  32'd0);
    chk("rst_hrdata", HRDATA,      32'h0);
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
    @(negedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Zero-wait read from slave 2.
    step(32'h2000_0010, NONSEQ, 4'hF, 1'b0);
    chk("hsel_s2", 32'(HSEL), 32'h4);
    expect_dp("rd_s2", 1'b1, 1'b0, D2);

    // Slave 1 with three wait states while the next address sits on the bus.
    step(32'h1000_0000, NONSEQ, 4'hF, 1'b0);
    chk("hsel_s1", 32'(HSEL), 32'h2);
    for (int k = 0; k < 3; k++) expect_dp("s1_wait", 1'b0, 1'b0, D1);
    expect_dp("s1_done", 1'b1, 1'b0, D1);
    step(32'h0000_0004, NONSEQ, 4'b1101, 1'b0);
    chk("hsel_s0_pending", 32'(HSEL), 32'h1);
    step(32'h0000_0004, NONSEQ, 4'b1101, 1'b0);
    step(32'h0000_0004, NONSEQ, 4'b1101, 1'b0);
    step(32'h0000_0004, NONSEQ, 4'hF, 1'b0);
    expect_dp("rd_s0", 1'b1, 1'b0, D0);

    // Unmapped NONSEQ: two-cycle ERROR.
    step(32'h8000_0000, NONSEQ, 4'hF, 1'b0);
    chk("hsel_none", 32'(HSEL), 32'h0);
    expect_dp("err_a1", 1'b0, 1'b1, 32'h0);
    expect_dp("err_a2", 1'b1, 1'b1, 32'h0);
    step(32'h0, IDLE, 4'hF, 1'b0);
    chk("errcnt_1", 32'(err_cnt), 32'd1);
    step(32'h0, IDLE, 4'hF, 1'b0);

    // Unmapped IDLE: plain OKAY, no count.
    step(32'h8000_0000, IDLE, 4'hF, 1'b0);
    expect_dp("idle_unmapped", 1'b1, 1'b0, 32'h0);
    step(32'h0, IDLE, 4'hF, 1'b0);
    chk("errcnt_idle", 32'(err_cnt), 32'd1);

    // Clear alone.
    step(32'h0, IDLE, 4'hF, 1'b1);
    step(32'h0, IDLE, 4'hF, 1'b0);
    chk("errcnt_clr", 32'(err_cnt), 32'd0);

    // Back-to-back unmapped NONSEQs, second accepted in DS_ERR2.
    step(32'h8000_0000, NONSEQ, 4'hF, 1'b0);
    expect_dp("b2b_a1", 1'b0, 1'b1, 32'h0);
    expect_dp("b2b_a2", 1'b1, 1'b1, 32'h0);
    step(32'h8000_0004, NONSEQ, 4'hF, 1'b0);
    step(32'h8000_0004, NONSEQ, 4'hF, 1'b0);
    expect_dp("b2b_b1", 1'b0, 1'b1, 32'h0);
    expect_dp("b2b_b2", 1'b1, 1'b1, 32'h0);
    step(32'h0, IDLE, 4'hF, 1'b0);
    step(32'h0, IDLE, 4'hF, 1'b0);
    chk("errcnt_b2b", 32'(err_cnt), 32'd2);

    // Saturation: a continuous unmapped stream yields well over 255 errors.
    for (int k = 0; k < 530; k++) step(32'h8000_0000, NONSEQ, 4'hF, 1'b0);
    step(32'h0, IDLE, 4'hF, 1'b0);
    step(32'h0, IDLE, 4'hF, 1'b0);
    chk("errcnt_sat", 32'(err_cnt), 32'd255);
    step(32'h0, IDLE, 4'hF, 1'b0);
    chk("errcnt_sat_hold", 32'(err_cnt), 32'd255);

    // Clear coinciding with a new error leaves one.
    step(32'h8000_0000, NONSEQ, 4'hF, 1'b1);
    step(32'h0, IDLE, 4'hF, 1'b0);
    chk("errcnt_clr_inc", 32'(err_cnt), 32'd1);
    step(32'h0, IDLE, 4'hF, 1'b0);
    step(32'h0, IDLE, 4'hF, 1'b0);

    // Reset in the middle of an ERROR response.
    step(32'h8000_0000, NONSEQ, 4'hF, 1'b0);
    step(32'h0, IDLE, 4'hF, 1'b0);
    chk("pre_rst_hready", 32'(HREADY), 32'd0);
    chk("pre_rst_errcnt", 32'(err_cnt), 32'd2);
    #2;
    HRESETn = 1'b0;
    #1;
    chk("midrst_hready", 32'(HREADY), 32'd1);
    chk("midrst_hresp",  32'(HRESP),  32'd0);
    chk("midrst_hrdata", HRDATA,      32'h0);
    chk("midrst_errcnt", 32'(err_cnt), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Post-reset read still works.
    step(32'h3000_0000, NONSEQ, 4'hF, 1'b0);
    expect_dp("rd_s3", 1'b1, 1'b0, D3);
    step(32'h0, IDLE, 4'hF, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
